// File: rtl/e1of2_chan_arbiter_pkg.sv
// Shared types and defaults for the 1-of-2 channel arbiter.
// Holds the FSM encoding and the round-robin pick helper.
package e1of2_chan_arbiter_pkg;

  localparam int SYNC_STAGES_D = 2;
  localparam int TIMEOUT_D     = 255;
  localparam int CNT_W_D       = 16;
  localparam int TCNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    NEUTRAL
  } state_e;

  // Tie goes to whoever was not granted last.
  function automatic logic rr_pick(
    input logic [1:0] v,
    input logic       last
  );
    return (&v) ? ~last : v[1];
  endfunction

endpackage

// File: rtl/e1of2_chan_arbiter_if.sv
// Requester handshake plus dual-rail channel toward the sink.
// master = requesters/sink side, slave = arbiter.
interface e1of2_chan_arbiter_if;

  logic [1:0] req_valid;
  logic [1:0] req_data;
  logic [1:0] req_ready;
  logic       l0;
  logic       l1;
  logic       le;

  modport master (
    output req_valid,
    output req_data,
    output le,
    input  req_ready,
    input  l0,
    input  l1
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  le,
    output req_ready,
    output l0,
    output l1
  );

endinterface

// File: rtl/e1of2_chan_arbiter_sync_ff.sv
// Reset-to-zero flop chain for bringing an async level into clk.
// DEPTH must be at least 2.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r;

  always_ff @(posedge clk) begin
    if (!rst_n) r <= '0;
    else        r <= {r[DEPTH-2:0], d};
  end

  assign q = r[DEPTH-1];

endmodule

// File: rtl/e1of2_chan_arbiter.sv
// Round-robin arbiter feeding one 1-of-2 four-phase RTZ channel.
// Rails, ready, busy and counters are all registered.
module e1of2_chan_arbiter
  import e1of2_chan_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int TIMEOUT     = TIMEOUT_D,
  parameter int CNT_W       = CNT_W_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e1of2_chan_arbiter_if.slave  ch,
  output logic                 grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1,
  output logic                 err_timeout
);

  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT - 1);

  logic              le_s;
  logic              last;
  logic              win;
  logic              win_d;
  logic [TCNT_W-1:0] tcnt;
  state_e            state;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_le_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ch.le),
    .q     (le_s)
  );

  assign win   = rr_pick(ch.req_valid, last);
  assign win_d = ch.req_data[win];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch.l0        <= 1'b0;
      ch.l1        <= 1'b0;
      ch.req_ready <= 2'b00;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      cnt0         <= '0;
      cnt1         <= '0;
      err_timeout  <= 1'b0;
      tcnt         <= '0;
      last         <= 1'b1;
    end else begin
      ch.req_ready <= 2'b00;
      unique case (state)
        IDLE: begin
          if (le_s && (|ch.req_valid)) begin
            state        <= DATA;
            busy         <= 1'b1;
            grant_id     <= win;
            last         <= win;
            ch.req_ready <= win ? 2'b10 : 2'b01;
            ch.l1        <= win_d;
            ch.l0        <= ~win_d;
            tcnt         <= '0;
          end
        end
        DATA: begin
          // Timeout only flags; the token stays on the rails.
          if (tcnt == TO_LAST) err_timeout <= 1'b1;
          if (tcnt != '1) tcnt <= tcnt + TCNT_W'(1);
          if (!le_s) begin
            state <= NEUTRAL;
            ch.l0 <= 1'b0;
            ch.l1 <= 1'b0;
          end
        end
        NEUTRAL: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (grant_id) cnt1 <= cnt1 + CNT_W'(1);
          else          cnt0 <= cnt0 + CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ch.l0 <= 1'b0;
          ch.l1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e1of2_chan_arbiter.sv
// Scoreboard bench: directed tokens queue expected grants,
// a negedge monitor pops and compares on every ready pulse.
module tb_e1of2_chan_arbiter;

  localparam int TO = 20;

  typedef struct packed {
    logic id;
    logic d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        grant_id, busy, err_timeout;
  logic [15:0] cnt0, cnt1;
  logic        s_grant_id, s_busy, s_err;
  logic [1:0]  s_cnt0, s_cnt1;

  int   checks = 0;
  int   errors = 0;
  int   rail_viol = 0;
  int   rail_viol2 = 0;
  exp_t exp_q[$];

  e1of2_chan_arbiter_if vif ();
  e1of2_chan_arbiter_if vif2 ();

  assign vif2.req_valid = vif.req_valid;
  assign vif2.req_data  = vif.req_data;
  assign vif2.le        = vif.le;

  always #5 clk = ~clk;

  e1of2_chan_arbiter #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TO),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch          (vif.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .err_timeout (err_timeout)
  );

  e1of2_chan_arbiter #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TO),
    .CNT_W       (2)
  ) dut_w2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch          (vif2.slave),
    .grant_id    (s_grant_id),
    .busy        (s_busy),
    .cnt0        (s_cnt0),
    .cnt1        (s_cnt1),
    .err_timeout (s_err)
  );

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (vif.l0 & vif.l1) rail_viol++;
    if (vif2.l0 & vif2.l1) rail_viol2++;
    if (vif.req_ready != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 32'(vif.req_ready), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("grant", {27'd0, vif.req_ready, grant_id, vif.l1, vif.l0},
            {27'd0, (e.id ? 2'b10 : 2'b01), e.id, e.d, ~e.d});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vif.req_ready == 2'b00 && n < 50);
    if (vif.req_ready == 2'b00) chk("ready_timeout", 32'(n), 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_rails", {30'd0, vif.l1, vif.l0}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vif.le = 1'b0;
    vif.req_valid = 2'b00;
    vif.req_data = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic token(input logic id, input logic d);
    exp_q.push_back('{id: id, d: d});
    vif.req_valid[id] = 1'b1;
    vif.req_data[id] = d;
    vif.le = 1'b1;
    wait_ready();
    vif.req_valid[id] = 1'b0;
    vif.le = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    vif.le = 1'b0;
    vif.req_valid = 2'b00;
    vif.req_data = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_rails", {30'd0, vif.l1, vif.l0}, 32'h0);
    chk("rst_ready", 32'(vif.req_ready), 32'h0);
    chk("rst_grant_busy", {30'd0, grant_id, busy}, 32'h0);
    chk("rst_cnt", {cnt0, cnt1}, 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);
    rst_n = 1'b1;

    // single token from requester 0, value 1
    exp_q.push_back('{id: 1'b0, d: 1'b1});
    vif.req_valid = 2'b01;
    vif.req_data = 2'b01;
    vif.le = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vif.l1 && n < 10);
    chk("l1_latency_ok", 32'(n > 0 && n <= 3), 32'h1);
    vif.req_valid = 2'b00;
    vif.le = 1'b0;
    wait_idle();
    chk("single_cnt0", 32'(cnt0), 32'h1);
    chk("single_cnt1", 32'(cnt1), 32'h0);

    // both valid continuously: grants alternate
    do_reset();
    vif.req_valid = 2'b11;
    vif.req_data = 2'b10;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{id: i[0], d: i[0]});
    end
    for (int i = 0; i < 8; i++) begin
      vif.le = 1'b1;
      wait_ready();
      vif.le = 1'b0;
      wait_idle();
    end
    vif.req_valid = 2'b00;
    chk("rr_cnt0", 32'(cnt0), 32'h4);
    chk("rr_cnt1", 32'(cnt1), 32'h4);
    chk("rr_w2_cnt", {30'd0, s_cnt0 | s_cnt1}, 32'h0);

    // narrow counters wrap
    do_reset();
    for (int i = 0; i < 5; i++) token(1'b1, i[0]);
    chk("wrap_cnt1", 32'(cnt1), 32'h5);
    chk("wrap_w2_cnt1", 32'(s_cnt1), 32'h1);
    chk("wrap_w2_cnt0", 32'(s_cnt0), 32'h0);

    // le low in IDLE blocks grants; raising it grants 0 first
    do_reset();
    vif.req_valid = 2'b11;
    vif.req_data = 2'b01;
    repeat (20) @(negedge clk);
    chk("hold_quiet", {29'd0, busy, vif.l1, vif.l0}, 32'h0);
    exp_q.push_back('{id: 1'b0, d: 1'b1});
    vif.le = 1'b1;
    wait_ready();
    vif.req_valid[0] = 1'b0;
    vif.le = 1'b0;
    wait_idle();
    exp_q.push_back('{id: 1'b1, d: 1'b0});
    vif.le = 1'b1;
    wait_ready();
    vif.req_valid = 2'b00;
    vif.le = 1'b0;
    wait_idle();
    chk("hold_cnt", {cnt0, cnt1}, {16'd1, 16'd1});

    // enable stuck high: sticky timeout, rail held
    do_reset();
    exp_q.push_back('{id: 1'b1, d: 1'b0});
    vif.req_valid = 2'b10;
    vif.req_data = 2'b00;
    vif.le = 1'b1;
    wait_ready();
    vif.req_valid = 2'b00;
    repeat (TO - 1) @(negedge clk);
    chk("to_not_yet", 32'(err_timeout), 32'h0);
    @(negedge clk);
    chk("to_set", 32'(err_timeout), 32'h1);
    repeat (10) @(negedge clk);
    chk("to_sticky", {29'd0, err_timeout, busy, vif.l0}, 32'h7);
    chk("to_l1_low", 32'(vif.l1), 32'h0);

    // reset while l0 high
    rst_n = 1'b0;
    vif.req_valid = 2'b01;
    vif.req_data = 2'b01;
    @(negedge clk);
    chk("mid_rst_rails", {30'd0, vif.l1, vif.l0}, 32'h0);
    chk("mid_rst_state", {29'd0, err_timeout, busy, grant_id}, 32'h0);
    chk("mid_rst_cnt", {cnt0, cnt1}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back('{id: 1'b0, d: 1'b1});
    wait_ready();
    vif.req_valid = 2'b00;
    vif.le = 1'b0;
    wait_idle();
    chk("post_rst_cnt0", 32'(cnt0), 32'h1);

    repeat (3) @(negedge clk);
    chk("rails_exclusive", 32'(rail_viol), 32'h0);
    chk("rails_exclusive_w2", 32'(rail_viol2), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
